// File: rtl/rob_mem_bridge_if.sv
// Handshake bundle between the ROB/memory environment (master) and rob_mem_bridge (slave).
// The master drives ROB requests, memory ready and memory responses; the slave drives the rest.
interface rob_mem_bridge_if #(
    parameter int SWIDTH = 4,
    parameter int AWIDTH = 40,
    parameter int DWIDTH = 32
);
    logic              rob_req_val;
    logic [AWIDTH-1:0] rob_req_addr;
    logic [SWIDTH-1:0] rob_req_ID;
    logic              rob_rsp_val;
    logic [SWIDTH-1:0] rob_rsp_ID;
    logic [DWIDTH-1:0] rob_rsp_data;
    logic              mem_req_val;
    logic [AWIDTH-1:0] mem_req_addr;
    logic [SWIDTH-1:0] mem_req_ID;
    logic              mem_req_ready;
    logic              mem_rsp_val;
    logic [SWIDTH-1:0] mem_rsp_ID;
    logic [DWIDTH-1:0] mem_rsp_data;
    logic              mem_rsp_ready;

    modport master (
        output rob_req_val, rob_req_addr, rob_req_ID,
        input  rob_rsp_val, rob_rsp_ID, rob_rsp_data,
        input  mem_req_val, mem_req_addr, mem_req_ID,
        output mem_req_ready,
        output mem_rsp_val, mem_rsp_ID, mem_rsp_data,
        input  mem_rsp_ready
    );

    modport slave (
        input  rob_req_val, rob_req_addr, rob_req_ID,
        output rob_rsp_val, rob_rsp_ID, rob_rsp_data,
        output mem_req_val, mem_req_addr, mem_req_ID,
        input  mem_req_ready,
        input  mem_rsp_val, mem_rsp_ID, mem_rsp_data,
        output mem_rsp_ready
    );
endinterface

// File: rtl/rob_mem_bridge.sv
// ROB-to-memory bridge: request FIFO with backpressure, in-flight tag tracking, registered responses.
// Optional zero-latency forwarding on an empty FIFO: define ROB_MEM_BRIDGE_BYPASS_EN.
module rob_mem_bridge #(
    parameter int ROB_SIZE = 16,
    parameter int SWIDTH   = 4,
    parameter int AWIDTH   = 40,
    parameter int DWIDTH   = 32
) (
    input  logic              clk,
    input  logic              rst_,
    rob_mem_bridge_if.slave   bus,
    output logic [SWIDTH:0]   inflight_cnt,
    output logic              err_ovf,
    output logic              err_dup,
    output logic              err_unexp
);
    localparam logic [SWIDTH:0] PTR_ONE  = {{SWIDTH{1'b0}}, 1'b1};
    localparam logic [SWIDTH:0] PTR_ZERO = {(SWIDTH+1){1'b0}};
    localparam logic [SWIDTH:0] CNT_MAX  = (SWIDTH+1)'(ROB_SIZE);

    logic [AWIDTH-1:0]   fifo_addr_q [ROB_SIZE];
    logic [SWIDTH-1:0]   fifo_id_q   [ROB_SIZE];
    logic [SWIDTH:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ROB_SIZE-1:0] inflight_q, inflight_d, inflight_clr_s;
    logic [SWIDTH:0]     cnt_q, cnt_d;
    logic                ovf_q, ovf_d, dup_q, dup_d, unexp_q, unexp_d;
    logic                rsp_val_q, rsp_val_d, rsp_ready_q, rsp_ready_d;
    logic [SWIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic                empty_s, full_s, pop_s, bypass_s, acc_s, fifo_wr_s;
    logic                rsp_hs_s, hit_s, miss_s;
    logic [SWIDTH-1:0]   rd_idx_s, wr_idx_s;

    // Handshake decode: FIFO status, push acceptance and response classification
    always_comb begin
        rd_idx_s = rd_ptr_q[SWIDTH-1:0];
        wr_idx_s = wr_ptr_q[SWIDTH-1:0];
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[SWIDTH] != rd_ptr_q[SWIDTH]) && (wr_idx_s == rd_idx_s);
        pop_s    = ~empty_s & bus.mem_req_ready;
`ifdef ROB_MEM_BRIDGE_BYPASS_EN
        bypass_s = empty_s & bus.mem_req_ready & bus.rob_req_val;
`else
        bypass_s = 1'b0;
`endif
        // A pop frees the slot this same cycle, so a full FIFO still accepts
        acc_s     = bus.rob_req_val & (~full_s | pop_s);
        fifo_wr_s = acc_s & ~bypass_s;
        rsp_hs_s  = bus.mem_rsp_val & rsp_ready_q;
        hit_s     = rsp_hs_s & inflight_q[bus.mem_rsp_ID];
        miss_s    = rsp_hs_s & ~inflight_q[bus.mem_rsp_ID];
    end

    // Next-state: pointers, bitmap (clear before set), counter, sticky flags, response register
    always_comb begin
        wr_ptr_d       = fifo_wr_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d       = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        inflight_clr_s = inflight_q;
        if (hit_s) begin
            inflight_clr_s[bus.mem_rsp_ID] = 1'b0;
        end else begin
            inflight_clr_s[bus.mem_rsp_ID] = inflight_q[bus.mem_rsp_ID];
        end
        inflight_d = inflight_clr_s;
        if (acc_s) begin
            inflight_d[bus.rob_req_ID] = 1'b1;
        end else begin
            inflight_d[bus.rob_req_ID] = inflight_clr_s[bus.rob_req_ID];
        end
        if (acc_s && !hit_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + PTR_ONE;
        end else if (hit_s && !acc_s && (cnt_q != PTR_ZERO)) begin
            cnt_d = cnt_q - PTR_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        // Tag reuse is flagged even when the request itself is dropped on overflow
        ovf_d       = ovf_q | (bus.rob_req_val & ~acc_s);
        dup_d       = dup_q | (bus.rob_req_val & inflight_clr_s[bus.rob_req_ID]);
        unexp_d     = unexp_q | miss_s;
        rsp_val_d   = hit_s;
        rsp_id_d    = hit_s ? bus.mem_rsp_ID : rsp_id_q;
        rsp_data_d  = hit_s ? bus.mem_rsp_data : rsp_data_q;
        rsp_ready_d = 1'b1;
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            inflight_q  <= {ROB_SIZE{1'b0}};
            cnt_q       <= PTR_ZERO;
            ovf_q       <= 1'b0;
            dup_q       <= 1'b0;
            unexp_q     <= 1'b0;
            rsp_val_q   <= 1'b0;
            rsp_id_q    <= {SWIDTH{1'b0}};
            rsp_data_q  <= {DWIDTH{1'b0}};
            rsp_ready_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            dup_q       <= dup_d;
            unexp_q     <= unexp_d;
            rsp_val_q   <= rsp_val_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ready_q <= rsp_ready_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers mark them empty
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            fifo_addr_q[wr_idx_s] <= bus.rob_req_addr;
            fifo_id_q[wr_idx_s]   <= bus.rob_req_ID;
        end else begin
            fifo_addr_q[wr_idx_s] <= fifo_addr_q[wr_idx_s];
            fifo_id_q[wr_idx_s]   <= fifo_id_q[wr_idx_s];
        end
    end

    // Memory request port: FIFO head, zeroed when empty (or the bypassed request)
    always_comb begin
        if (bypass_s) begin
            bus.mem_req_val  = 1'b1;
            bus.mem_req_addr = bus.rob_req_addr;
            bus.mem_req_ID   = bus.rob_req_ID;
        end else if (empty_s) begin
            bus.mem_req_val  = 1'b0;
            bus.mem_req_addr = {AWIDTH{1'b0}};
            bus.mem_req_ID   = {SWIDTH{1'b0}};
        end else begin
            bus.mem_req_val  = 1'b1;
            bus.mem_req_addr = fifo_addr_q[rd_idx_s];
            bus.mem_req_ID   = fifo_id_q[rd_idx_s];
        end
    end

    assign bus.rob_rsp_val   = rsp_val_q;
    assign bus.rob_rsp_ID    = rsp_id_q;
    assign bus.rob_rsp_data  = rsp_data_q;
    assign bus.mem_rsp_ready = rsp_ready_q;
    assign inflight_cnt      = cnt_q;
    assign err_ovf           = ovf_q;
    assign err_dup           = dup_q;
    assign err_unexp         = unexp_q;
endmodule

// File: tb/tb_rob_mem_bridge.sv
// Bench for rob_mem_bridge: directed scenarios plus random traffic against a queue-based model.
module tb_rob_mem_bridge;
    localparam int RS = 16;
    localparam int SW = 4;
    localparam int AW = 40;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    rob_mem_bridge_if #(.SWIDTH(SW), .AWIDTH(AW), .DWIDTH(DW)) bus ();
    logic [SW:0] inflight_cnt;
    logic        err_ovf, err_dup, err_unexp;

    rob_mem_bridge #(.ROB_SIZE(RS), .SWIDTH(SW), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .bus          (bus),
        .inflight_cnt (inflight_cnt),
        .err_ovf      (err_ovf),
        .err_dup      (err_dup),
        .err_unexp    (err_unexp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: request queue, set of in-flight tags, counts and flags
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [SW-1:0] id;
    } req_t;
    req_t          m_q[$];
    bit            m_inf[RS];
    int            m_cnt;
    bit            m_ovf, m_dup, m_unexp, m_rvalid, m_rdy;
    logic [SW-1:0] m_rid;
    logic [DW-1:0] m_rdata;

    function automatic bit model_bypass();
`ifdef ROB_MEM_BRIDGE_BYPASS_EN
        return (m_q.size() == 0) && bus.mem_req_ready && bus.rob_req_val;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        bit hs, hit, pop, bp, acc;
        if (!rst_) begin
            m_q.delete();
            foreach (m_inf[i]) m_inf[i] = 1'b0;
            m_cnt = 0; m_ovf = 0; m_dup = 0; m_unexp = 0;
            m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rdy = 0;
        end else begin
            hs  = bus.mem_rsp_val && m_rdy;
            hit = hs && m_inf[bus.mem_rsp_ID];
            pop = (m_q.size() > 0) && bus.mem_req_ready;
            bp  = model_bypass();
            acc = bus.rob_req_val && ((m_q.size() < RS) || pop);
            if (hs && !hit) m_unexp = 1;
            if (hit) m_inf[bus.mem_rsp_ID] = 1'b0;
            if (bus.rob_req_val && m_inf[bus.rob_req_ID]) m_dup = 1;
            if (bus.rob_req_val && !acc) m_ovf = 1;
            if (acc) m_inf[bus.rob_req_ID] = 1'b1;
            m_cnt = m_cnt + int'(acc) - int'(hit);
            if (m_cnt > RS) m_cnt = RS;
            if (m_cnt < 0) m_cnt = 0;
            if (pop) void'(m_q.pop_front());
            if (acc && !bp) m_q.push_back('{addr: bus.rob_req_addr, id: bus.rob_req_ID});
            m_rvalid = hit;
            if (hit) begin
                m_rid   = bus.mem_rsp_ID;
                m_rdata = bus.mem_rsp_data;
            end
            m_rdy = 1;
        end
    endtask

    task automatic check_outputs();
        bit            bp;
        bit            ev;
        logic [AW-1:0] ea;
        logic [SW-1:0] ei;
        bp = model_bypass();
        if (m_q.size() > 0) begin
            ev = 1; ea = m_q[0].addr; ei = m_q[0].id;
        end else if (bp) begin
            ev = 1; ea = bus.rob_req_addr; ei = bus.rob_req_ID;
        end else begin
            ev = 0; ea = '0; ei = '0;
        end
        check("mem_req_val",   64'(bus.mem_req_val),   64'(ev));
        check("mem_req_addr",  64'(bus.mem_req_addr),  64'(ea));
        check("mem_req_ID",    64'(bus.mem_req_ID),    64'(ei));
        check("rob_rsp_val",   64'(bus.rob_rsp_val),   64'(m_rvalid));
        check("rob_rsp_ID",    64'(bus.rob_rsp_ID),    64'(m_rid));
        check("rob_rsp_data",  64'(bus.rob_rsp_data),  64'(m_rdata));
        check("mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(m_rdy));
        check("inflight_cnt",  64'(inflight_cnt),      64'(m_cnt));
        check("err_ovf",       64'(err_ovf),           64'(m_ovf));
        check("err_dup",       64'(err_dup),           64'(m_dup));
        check("err_unexp",     64'(err_unexp),         64'(m_unexp));
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.rob_req_val  = 1'b0;
        bus.rob_req_addr = '0;
        bus.rob_req_ID   = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_val  = 1'b0;
        bus.mem_rsp_ID   = '0;
        bus.mem_rsp_data = '0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [SW-1:0] id);
        bus.rob_req_val  = 1'b1;
        bus.rob_req_addr = a;
        bus.rob_req_ID   = id;
        tick();
        bus.rob_req_val  = 1'b0;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] rdat[4];
        logic [SW-1:0] order[4];
        int            tags[$];
        idle();
        rst_ = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        tick();
        rst_ = 1'b1;

        // Reset then single request
        bus.mem_req_ready = 1'b1;
        push(40'h10, 4'd3);
        check("t1_cnt", 64'(inflight_cnt), 64'd1);
`ifndef ROB_MEM_BRIDGE_BYPASS_EN
        check("t1_val",  64'(bus.mem_req_val),  64'd1);
        check("t1_addr", 64'(bus.mem_req_addr), 64'h10);
        check("t1_id",   64'(bus.mem_req_ID),   64'd3);
        tick();
`endif
        bus.mem_rsp_val = 1'b1; bus.mem_rsp_ID = 4'd3; bus.mem_rsp_data = 32'hA5;
        tick();
        bus.mem_rsp_val = 1'b0;
        check("t1_rsp_val",  64'(bus.rob_rsp_val),  64'd1);
        check("t1_rsp_id",   64'(bus.rob_rsp_ID),   64'd3);
        check("t1_rsp_data", 64'(bus.rob_rsp_data), 64'hA5);
        check("t1_cnt0",     64'(inflight_cnt),     64'd0);

        // Backpressure fill, overflow, duplicate tag, in-order drain
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < RS; i++) push(40'(i * 256), 4'(i));
        push(40'hDEAD, 4'd0);
        check("t2_ovf", 64'(err_ovf), 64'd1);
        check("t2_dup", 64'(err_dup), 64'd1);
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < RS; i++) begin
            check("t2_drain_val", 64'(bus.mem_req_val), 64'd1);
            check("t2_drain_id",  64'(bus.mem_req_ID),  64'(i));
            tick();
        end
        check("t2_drained", 64'(bus.mem_req_val), 64'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < RS; i++) push(40'(i * 16), 4'(i));
        bus.mem_rsp_val = 1'b1; bus.mem_rsp_ID = 4'd5; bus.mem_rsp_data = 32'h55;
        tick();
        bus.mem_rsp_val = 1'b0;
        bus.mem_req_ready = 1'b1;
        push(40'hABC, 4'd5);
        check("t3_ovf", 64'(err_ovf),      64'd0);
        check("t3_dup", 64'(err_dup),      64'd0);
        check("t3_cnt", 64'(inflight_cnt), 64'd16);
        for (int i = 1; i < RS; i++) begin
            check("t3_order", 64'(bus.mem_req_ID), 64'(i));
            tick();
        end
        check("t3_last_id",   64'(bus.mem_req_ID),   64'd5);
        check("t3_last_addr", 64'(bus.mem_req_addr), 64'hABC);
        tick();
        check("t3_empty", 64'(bus.mem_req_val), 64'd0);

        // Out-of-order responses
        do_reset();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(40'(i + 100), 4'(i));
        tick();
        check("t4_cnt4", 64'(inflight_cnt), 64'd4);
        order[0] = 4'd2; order[1] = 4'd0; order[2] = 4'd3; order[3] = 4'd1;
        for (int j = 0; j < 4; j++) begin
            rdat[j] = $urandom;
            bus.mem_rsp_val = 1'b1; bus.mem_rsp_ID = order[j]; bus.mem_rsp_data = rdat[j];
            tick();
            check("t4_rsp_val",  64'(bus.rob_rsp_val),  64'd1);
            check("t4_rsp_id",   64'(bus.rob_rsp_ID),   64'(order[j]));
            check("t4_rsp_data", 64'(bus.rob_rsp_data), 64'(rdat[j]));
            check("t4_cnt",      64'(inflight_cnt),     64'(3 - j));
        end

        // Unexpected response
        bus.mem_rsp_val = 1'b1; bus.mem_rsp_ID = 4'd7; bus.mem_rsp_data = 32'h77;
        tick();
        bus.mem_rsp_val = 1'b0;
        check("t5_unexp",   64'(err_unexp),       64'd1);
        check("t5_rsp_val", 64'(bus.rob_rsp_val), 64'd0);
        check("t5_cnt",     64'(inflight_cnt),    64'd0);

        // Reset mid-operation
        do_reset();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(40'(i + 200), 4'(8 + i));
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(40'(i + 300), 4'(13 + i));
        rst_ = 1'b0;
        tick();
        check("t6_mreq_val",  64'(bus.mem_req_val),   64'd0);
        check("t6_mreq_addr", 64'(bus.mem_req_addr),  64'd0);
        check("t6_mreq_id",   64'(bus.mem_req_ID),    64'd0);
        check("t6_rsp_val",   64'(bus.rob_rsp_val),   64'd0);
        check("t6_rsp_id",    64'(bus.rob_rsp_ID),    64'd0);
        check("t6_rsp_data",  64'(bus.rob_rsp_data),  64'd0);
        check("t6_rsp_rdy",   64'(bus.mem_rsp_ready), 64'd0);
        check("t6_cnt",       64'(inflight_cnt),      64'd0);
        check("t6_errs",      64'({err_ovf, err_dup, err_unexp}), 64'd0);
        rst_ = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_ = ($urandom_range(299, 0) != 0);
            bus.rob_req_val   = $urandom_range(1, 0);
            bus.rob_req_addr  = {8'($urandom), 32'($urandom)};
            bus.rob_req_ID    = 4'($urandom_range(RS - 1, 0));
            bus.mem_req_ready = ($urandom_range(9, 0) < 7);
            bus.mem_rsp_val   = $urandom_range(1, 0);
            bus.mem_rsp_data  = $urandom;
            tags.delete();
            for (int t = 0; t < RS; t++) if (m_inf[t]) tags.push_back(t);
            if (tags.size() > 0 && $urandom_range(9, 0) < 8)
                bus.mem_rsp_ID = 4'(tags[$urandom_range(tags.size() - 1, 0)]);
            else
                bus.mem_rsp_ID = 4'($urandom_range(RS - 1, 0));
            tick();
        end
        idle();
        rst_ = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
